// File: rtl/ing_record_tx.sv
// ing_record_tx: captures {pl, op} records and serializes them LSB-first onto
// an AXI-stream style beat interface, one beat per clock when unstalled.
// Optional feature macro: ING_RECORD_TX_SEQ_EN prepends a header beat per
// record whose low 8 bits carry a wrapping 8-bit sequence number.
module ing_record_tx #(
  parameter int NUM   = 6,
  parameter int DSIZE = 8
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_op,
  input  logic [NUM-1:0]   in_pl,
  output logic [DSIZE-1:0] axis_tdata,
  output logic             axis_tvalid,
  input  logic             axis_tready,
  output logic             axis_tlast
);
  localparam int W      = 32 + NUM;
  localparam int DBEATS = (W + DSIZE - 1) / DSIZE;
  localparam int DW     = DBEATS * DSIZE;
`ifdef ING_RECORD_TX_SEQ_EN
  localparam int BEATS  = DBEATS + 1;
`else
  localparam int BEATS  = DBEATS;
`endif
  localparam int SW     = BEATS * DSIZE;
  localparam int CW     = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [SW-1:0] shift_q;
  logic          tlast_q;
  logic [DW-1:0] recPad;
  logic [SW-1:0] loadWord;
  logic          outFire;
  logic          lastFire;
  logic          inFire;
`ifdef ING_RECORD_TX_SEQ_EN
  logic [7:0]       seq_q;
  logic [DSIZE-1:0] hdrBeat;
`endif

  assign axis_tvalid = (state_q == SEND);
  assign axis_tdata  = shift_q[DSIZE-1:0];
  assign axis_tlast  = tlast_q;

  assign outFire  = axis_tvalid && axis_tready;
  assign lastFire = outFire && tlast_q;
  // Accept a new record when idle, or in the very cycle the final beat leaves
  // so consecutive records stream without a bubble.
  assign in_ready = !rst && ((state_q == IDLE) || lastFire);
  assign inFire   = in_valid && in_ready;
  assign cnt_d    = cnt_q + CW'(1);

  // Zero-extend the incoming record to a whole number of beats.
  always_comb begin
    recPad        = '0;
    recPad[W-1:0] = {in_pl, in_op};
  end

`ifdef ING_RECORD_TX_SEQ_EN
  // Header beat carries the sequence number in its low byte, upper bits zero.
  always_comb begin
    hdrBeat      = '0;
    hdrBeat[7:0] = seq_q;
  end

  assign loadWord = {recPad, hdrBeat};

  // Sequence number advances each time a header beat is taken downstream.
  always_ff @(posedge clock) begin
    if (rst) begin
      seq_q <= '0;
    end else if (outFire && (cnt_q == '0)) begin
      seq_q <= seq_q + 8'd1;
    end
  end
`else
  assign loadWord = recPad;
`endif

  // Record FSM: load on input handshake, shift one beat out per output
  // handshake, reload directly on a last-beat/new-record overlap.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      tlast_q <= 1'b0;
    end else if (inFire) begin
      state_q <= SEND;
      cnt_q   <= '0;
      shift_q <= loadWord;
      tlast_q <= (BEATS == 1);
    end else if (lastFire) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tlast_q <= 1'b0;
    end else if (outFire) begin
      cnt_q   <= cnt_d;
      shift_q <= shift_q >> DSIZE;
      tlast_q <= (cnt_d == CW'(BEATS - 1));
    end
  end

endmodule

// File: tb/tb_ing_record_tx.sv
// tb_ing_record_tx: randomized and directed checks of ing_record_tx against a
// beat-queue reference model; a second instance covers the padded-beat case.
`timescale 1ns/1ps
module tb_ing_record_tx;
  localparam int NUM    = 6;
  localparam int DSIZE  = 8;
  localparam int W      = 32 + NUM;
  localparam int DBEATS = (W + DSIZE - 1) / DSIZE;
`ifdef ING_RECORD_TX_SEQ_EN
  localparam int HB     = 1;
`else
  localparam int HB     = 0;
`endif
  localparam int BEATS  = DBEATS + HB;

  logic             clock = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_op;
  logic [NUM-1:0]   in_pl;
  logic [DSIZE-1:0] axis_tdata;
  logic             axis_tvalid;
  logic             axis_tready;
  logic             axis_tlast;

  logic             in_valid2;
  logic             in_ready2;
  logic [31:0]      in_op2;
  logic [0:0]       in_pl2;
  logic [15:0]      tdata2;
  logic             tvalid2;
  logic             tready2;
  logic             tlast2;

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic        hdr;
  } beat_t;

  beat_t       expQ[$];
  logic [63:0] obsData[$];
  logic        obsLast[$];
  int          hdrCnt;
  bit          rstPrev;
  int          checks;
  int          errors;

  ing_record_tx #(.NUM(NUM), .DSIZE(DSIZE)) dut (
    .clock(clock), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_pl(in_pl), .axis_tdata(axis_tdata),
    .axis_tvalid(axis_tvalid), .axis_tready(axis_tready), .axis_tlast(axis_tlast)
  );

  ing_record_tx #(.NUM(1), .DSIZE(16)) dut2 (
    .clock(clock), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_op(in_op2), .in_pl(in_pl2), .axis_tdata(tdata2),
    .axis_tvalid(tvalid2), .axis_tready(tready2), .axis_tlast(tlast2)
  );

  always #5 clock = ~clock;

  // Global time bound so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Expected beats of one record, derived from the record word arithmetic.
  task automatic pushRecord(input logic [31:0] op, input logic [NUM-1:0] pl);
    logic [127:0] rec;
    beat_t        b;
    rec = (128'(pl) << 32) | 128'(op);
    if (HB == 1) begin
      b.data = 64'(hdrCnt % 256);
      b.last = 1'b0;
      b.hdr  = 1'b1;
      expQ.push_back(b);
    end
    for (int k = 0; k < DBEATS; k++) begin
      b.data = 64'((rec >> (k * DSIZE)) & ((128'd1 << DSIZE) - 128'd1));
      b.last = (k == DBEATS - 1);
      b.hdr  = 1'b0;
      expQ.push_back(b);
    end
  endtask

  // One clock of stimulus, called at a falling edge; checks outputs mid-cycle
  // and advances the model at the rising edge.
  task automatic applyStimulus(input logic v, input logic [31:0] op, input logic [NUM-1:0] pl,
                               input logic rdy, input logic r, output bit inAcc, output bit outAcc);
    bit expValid;
    bit expReady;
    rst = r; in_valid = v; in_op = op; in_pl = pl; axis_tready = rdy;
    #1;
    expValid = (expQ.size() > 0);
    expReady = !r && ((expQ.size() == 0) || ((expQ.size() == 1) && rdy));
    checkOutput("in_ready", 64'(in_ready), 64'(expReady));
    checkOutput("tvalid", 64'(axis_tvalid), 64'(expValid));
    if (expValid) begin
      checkOutput("tdata", 64'(axis_tdata), expQ[0].data);
      checkOutput("tlast", 64'(axis_tlast), 64'(expQ[0].last));
    end
    if (rstPrev) begin
      checkOutput("rst_tdata", 64'(axis_tdata), 64'h0);
      checkOutput("rst_tlast", 64'(axis_tlast), 64'h0);
    end
    outAcc = expValid && rdy && !r;
    inAcc  = v && expReady;
    if (outAcc) begin
      obsData.push_back(64'(axis_tdata));
      obsLast.push_back(axis_tlast);
    end
    @(posedge clock);
    if (r) begin
      expQ.delete();
      hdrCnt  = 0;
      rstPrev = 1'b1;
    end else begin
      rstPrev = 1'b0;
      if (outAcc) begin
        if (expQ[0].hdr) hdrCnt++;
        void'(expQ.pop_front());
      end
      if (inAcc) pushRecord(op, pl);
    end
    @(negedge clock);
  endtask

  task automatic compareLists(input string tag, input logic [63:0] lit[$]);
    checkOutput({tag, "_count"}, 64'(obsData.size()), 64'(lit.size()));
    for (int i = 0; i < lit.size() && i < obsData.size(); i++) begin
      checkOutput($sformatf("%s_beat%0d", tag, i), obsData[i], lit[i]);
      checkOutput($sformatf("%s_last%0d", tag, i), 64'(obsLast[i]), 64'(i == lit.size() - 1));
    end
  endtask

  task automatic runToLast(input string tag, input int budget);
    bit ia, oa, done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      applyStimulus(1'b0, $urandom, NUM'($urandom), 1'b1, 1'b0, ia, oa);
      if (oa && obsLast[$]) done = 1'b1;
    end
    checkOutput({tag, "_done"}, 64'(done), 64'h1);
  endtask

  initial begin
    bit          ia, oa, done;
    logic [63:0] lit[$];
    int          accepted, cyc, acc2Cycle, firstOut, lastOut, stall;
    logic [31:0] rOp;
    logic [NUM-1:0] rPl;

    checks = 0; errors = 0; hdrCnt = 0; rstPrev = 1'b1;
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_pl = '0; axis_tready = 1'b0;
    in_valid2 = 1'b0; in_op2 = '0; in_pl2 = '0; tready2 = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    applyStimulus(1'b0, 32'h0, '0, 1'b0, 1'b1, ia, oa);

    // Single record, literal beats.
    $display("[TB] single record");
    obsData.delete(); obsLast.delete();
    applyStimulus(1'b1, 32'h12345678, 6'h2A, 1'b1, 1'b0, ia, oa);
    checkOutput("t1_accept", 64'(ia), 64'h1);
    runToLast("t1", 20);
`ifdef ING_RECORD_TX_SEQ_EN
    lit = '{64'h00, 64'h78, 64'h56, 64'h34, 64'h12, 64'h2A};
`else
    lit = '{64'h78, 64'h56, 64'h34, 64'h12, 64'h2A};
`endif
    compareLists("t1", lit);

    // Backpressure on data beat 2.
    $display("[TB] backpressure");
    obsData.delete(); obsLast.delete();
    applyStimulus(1'b1, 32'h12345678, 6'h2A, 1'b1, 1'b0, ia, oa);
    done = 1'b0; stall = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      logic rdy;
      rdy = 1'b1;
      if (obsData.size() == 2 + HB && stall < 3) begin
        rdy = 1'b0;
        stall++;
        checkOutput("t2_hold", 64'(axis_tdata), 64'h34);
      end
      applyStimulus(1'b0, $urandom, NUM'($urandom), rdy, 1'b0, ia, oa);
      if (oa && obsLast[$]) done = 1'b1;
    end
    checkOutput("t2_done", 64'(done), 64'h1);
    checkOutput("t2_stalls", 64'(stall), 64'd3);
`ifdef ING_RECORD_TX_SEQ_EN
    lit = '{64'h01, 64'h78, 64'h56, 64'h34, 64'h12, 64'h2A};
`else
    lit = '{64'h78, 64'h56, 64'h34, 64'h12, 64'h2A};
`endif
    compareLists("t2", lit);

    // Back-to-back records with the sink always ready.
    $display("[TB] back-to-back");
    obsData.delete(); obsLast.delete();
    accepted = 0; acc2Cycle = -1; firstOut = -1; lastOut = -1;
    for (cyc = 0; cyc < 40 && obsData.size() < 2 * BEATS; cyc++) begin
      rOp = (accepted == 0) ? 32'h11223344 : 32'h55667788;
      rPl = (accepted == 0) ? 6'h15 : 6'h3F;
      applyStimulus(accepted < 2, rOp, rPl, 1'b1, 1'b0, ia, oa);
      if (ia) begin
        accepted++;
        if (accepted == 2) acc2Cycle = cyc;
      end
      if (oa) begin
        if (firstOut < 0) firstOut = cyc;
        lastOut = cyc;
      end
    end
    checkOutput("t3_beats", 64'(obsData.size()), 64'(2 * BEATS));
    checkOutput("t3_span", 64'(lastOut - firstOut + 1), 64'(2 * BEATS));
    checkOutput("t3_acc2", 64'(acc2Cycle), 64'(BEATS));
    checkOutput("t3_first", 64'(firstOut), 64'd1);

    // Reset while beat 3 is presented.
    $display("[TB] reset mid-record");
    obsData.delete(); obsLast.delete();
    applyStimulus(1'b1, 32'h12345678, 6'h2A, 1'b1, 1'b0, ia, oa);
    for (int c = 0; c < 20 && obsData.size() < 3 + HB; c++)
      applyStimulus(1'b0, $urandom, NUM'($urandom), 1'b1, 1'b0, ia, oa);
    checkOutput("t4_pre", 64'(obsData.size()), 64'(3 + HB));
    applyStimulus(1'b0, 32'h0, '0, 1'b1, 1'b1, ia, oa);
    checkOutput("t4_tvalid", 64'(axis_tvalid), 64'h0);
    obsData.delete(); obsLast.delete();
    applyStimulus(1'b1, 32'hA1B2C3D4, 6'h07, 1'b1, 1'b0, ia, oa);
    checkOutput("t4_accept", 64'(ia), 64'h1);
    runToLast("t4", 20);
    checkOutput("t4_count", 64'(obsData.size()), 64'(BEATS));
    if (obsData.size() > 0)
      checkOutput("t4_first", obsData[0], (HB == 1) ? 64'h00 : 64'hD4);

`ifdef ING_RECORD_TX_SEQ_EN
    // 257 records: header sequence wraps.
    $display("[TB] sequence wrap");
    applyStimulus(1'b0, 32'h0, '0, 1'b1, 1'b1, ia, oa);
    obsData.delete(); obsLast.delete();
    accepted = 0;
    for (int c = 0; c < 257 * BEATS + 50 && obsData.size() < 257 * BEATS; c++) begin
      applyStimulus(accepted < 257, $urandom, NUM'($urandom), 1'b1, 1'b0, ia, oa);
      if (ia) accepted++;
    end
    checkOutput("t5_beats", 64'(obsData.size()), 64'(257 * BEATS));
    if (obsData.size() == 257 * BEATS) begin
      checkOutput("t5_hdr0", obsData[0], 64'h00);
      checkOutput("t5_hdr255", obsData[255 * BEATS], 64'hFF);
      checkOutput("t5_hdr256", obsData[256 * BEATS], 64'h00);
      checkOutput("t5_last", 64'(obsLast[BEATS - 1]), 64'h1);
    end
`endif

    // Randomized traffic, stalls and occasional resets.
    $display("[TB] random traffic");
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(1'($urandom % 2), $urandom, NUM'($urandom), 1'($urandom % 4 != 0),
                    1'($urandom % 150 == 0), ia, oa);
    end

    // Padded last beat on a NUM=1, DSIZE=16 instance.
    $display("[TB] zero padding");
    rst = 1'b0; in_valid = 1'b0; axis_tready = 1'b1;
    in_valid2 = 1'b1; in_op2 = 32'h12345678; in_pl2 = 1'b1; tready2 = 1'b1;
    #1;
    checkOutput("t6_ready", 64'(in_ready2), 64'h1);
    @(posedge clock);
    @(negedge clock);
    in_valid2 = 1'b0; in_op2 = 32'hFFFFFFFF; in_pl2 = 1'b0;
    obsData.delete(); obsLast.delete();
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      #1;
      if (tvalid2) begin
        obsData.push_back(64'(tdata2));
        obsLast.push_back(tlast2);
        if (tlast2) done = 1'b1;
      end
      @(negedge clock);
    end
    checkOutput("t6_done", 64'(done), 64'h1);
`ifdef ING_RECORD_TX_SEQ_EN
    lit = '{64'h0000, 64'h5678, 64'h1234, 64'h0001};
`else
    lit = '{64'h5678, 64'h1234, 64'h0001};
`endif
    compareLists("t6", lit);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
